// File: rtl/adder_seq_64bit_if.sv
// Operand/result bundle for adder_seq_64bit: start request, operands and completed sum.
interface adder_seq_64bit_if #(
    parameter int NUM_SLICES = 4
);
    localparam int W = 16 * NUM_SLICES;

    logic         inStart;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         inCarry;
    logic         outBusy;
    logic         outDone;
    logic [W-1:0] outSum;
    logic         outCarry;
    logic         outOverflow;

    modport master (
        output inStart, inA, inB, inCarry,
        input  outBusy, outDone, outSum, outCarry, outOverflow
    );

    modport slave (
        input  inStart, inA, inB, inCarry,
        output outBusy, outDone, outSum, outCarry, outOverflow
    );
endinterface

// File: rtl/adder_seq_64bit.sv
// Multi-cycle wide adder reusing one 16-bit carry-select slice, LSB-first.
// Optional signed-overflow flag built only when ADDER_SEQ_OVERFLOW_EN is defined.

module adder_cs_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] sum_o,
    output logic        c_o
);
    logic [8:0] lo;
    logic [8:0] hi0;
    logic [8:0] hi1;

    // Upper byte is computed for both carry values and selected by the lower carry.
    assign lo    = {1'b0, a_i[7:0]} + {1'b0, b_i[7:0]} + {8'b0, c_i};
    assign hi0   = {1'b0, a_i[15:8]} + {1'b0, b_i[15:8]};
    assign hi1   = hi0 + 9'd1;
    assign sum_o = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
    assign c_o   = lo[8] ? hi1[8] : hi0[8];
endmodule

// state  | meaning
// S_IDLE | waiting for inStart, operands captured on acceptance
// S_RUN  | one 16-bit slice per cycle, carry fed back through carry_q
// S_DONE | one-cycle outDone pulse, results already loaded
module adder_seq_64bit #(
    parameter int NUM_SLICES = 4
) (
    input  logic               clk,
    input  logic               rst,
    adder_seq_64bit_if.slave   bus
);
    localparam int W     = 16 * NUM_SLICES;
    localparam int IDX_W = $clog2(NUM_SLICES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic [W-1:0]     work_q, work_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [IDX_W+3:0] shamt;
    logic [15:0]      slice_a, slice_b, slice_sum;
    logic             slice_cout;
    logic [W-1:0]     slice_ins, slice_mask;
    logic             accept, last_slice;

    assign shamt      = {idx_q, 4'b0000};
    assign slice_a    = 16'(op_a_q >> shamt);
    assign slice_b    = 16'(op_b_q >> shamt);
    assign slice_ins  = W'(slice_sum) << shamt;
    assign slice_mask = W'(16'hFFFF) << shamt;
    assign accept     = (state_q == S_IDLE) && bus.inStart;
    assign last_slice = (state_q == S_RUN) && (idx_q == LAST_IDX);

    adder_cs_16bit u_slice (
        .a_i   (slice_a),
        .b_i   (slice_b),
        .c_i   (carry_q),
        .sum_o (slice_sum),
        .c_o   (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.inStart) state_d = S_RUN;
            S_RUN:   if (last_slice) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.outBusy = (state_q != S_IDLE);
        bus.outDone = (state_q == S_DONE);
    end

    // Results load on the final RUN edge so they are visible during the DONE cycle.
    always_comb begin
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (accept) begin
            op_a_d  = bus.inA;
            op_b_d  = bus.inB;
            carry_d = bus.inCarry;
            idx_d   = '0;
            work_d  = '0;
        end else if (state_q == S_RUN) begin
            work_d  = (work_q & ~slice_mask) | slice_ins;
            carry_d = slice_cout;
            idx_d   = idx_q + 1'b1;
            if (last_slice) begin
                sum_d  = work_d;
                cout_d = slice_cout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef ADDER_SEQ_OVERFLOW_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (last_slice) begin
            ovf_d = (op_a_q[W-1] == op_b_q[W-1]) && (work_d[W-1] != op_a_q[W-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.outOverflow = ovf_q;
`else
    assign bus.outOverflow = 1'b0;
`endif

    assign bus.outSum   = sum_q;
    assign bus.outCarry = cout_q;
endmodule

// File: tb/tb_adder_seq_64bit.sv
// Bench for adder_seq_64bit: 4-slice and 1-slice instances checked every cycle
// against a timing/arithmetic model, plus hand-computed directed results.
module tb_adder_seq_64bit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_seq_64bit_if #(.NUM_SLICES(4)) bus4 ();
    adder_seq_64bit_if #(.NUM_SLICES(1)) bus1 ();

    adder_seq_64bit #(.NUM_SLICES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    adder_seq_64bit #(.NUM_SLICES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_en = 0;
    int done1_cnt = 0;

    typedef struct {
        int          cnt;
        logic [63:0] p_sum;
        logic        p_cy;
        logic        p_ovf;
        logic [63:0] sum;
        logic        cy;
        logic        ovf;
    } model_t;

    model_t m4, m1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // cnt: 0 idle, 1..n computing, n+1 the done cycle.
    task automatic step(inout model_t m, input int n, input logic r, input logic st,
                        input logic [63:0] a, input logic [63:0] b, input logic ci);
        logic [64:0] full;
        logic [63:0] mask;
        int w;
        w = 16 * n;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        if (r) begin
            m.cnt = 0; m.sum = '0; m.cy = 1'b0; m.ovf = 1'b0;
        end else if (m.cnt == 0) begin
            if (st) begin
                full = {1'b0, a & mask} + {1'b0, b & mask} + 65'(ci);
                m.p_sum = full[63:0] & mask;
                m.p_cy = full[w];
                m.p_ovf = 1'b0;
`ifdef ADDER_SEQ_OVERFLOW_EN
                m.p_ovf = (a[w-1] == b[w-1]) && (m.p_sum[w-1] != a[w-1]);
`endif
                m.cnt = 1;
            end
        end else if (m.cnt == n + 1) begin
            m.cnt = 0;
        end else begin
            m.cnt++;
            if (m.cnt == n + 1) begin
                m.sum = m.p_sum; m.cy = m.p_cy; m.ovf = m.p_ovf;
            end
        end
    endtask

    always @(posedge clk) begin
        step(m4, 4, rst, bus4.inStart, bus4.inA, bus4.inB, bus4.inCarry);
        step(m1, 1, rst, bus1.inStart, 64'(bus1.inA), 64'(bus1.inB), bus1.inCarry);
        cyc++;
        cmp_en = 1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy4", 64'(bus4.outBusy), 64'(m4.cnt != 0));
            chk("done4", 64'(bus4.outDone), 64'(m4.cnt == 5));
            chk("sum4", bus4.outSum, m4.sum);
            chk("carry4", 64'(bus4.outCarry), 64'(m4.cy));
            chk("ovf4", 64'(bus4.outOverflow), 64'(m4.ovf));
            chk("busy1", 64'(bus1.outBusy), 64'(m1.cnt != 0));
            chk("done1", 64'(bus1.outDone), 64'(m1.cnt == 2));
            chk("sum1", 64'(bus1.outSum), m1.sum);
            chk("carry1", 64'(bus1.outCarry), 64'(m1.cy));
            chk("ovf1", 64'(bus1.outOverflow), 64'(m1.ovf));
            if (bus1.outDone === 1'b1) done1_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start4(input logic [63:0] a, input logic [63:0] b, input logic ci);
        bus4.inA = a; bus4.inB = b; bus4.inCarry = ci; bus4.inStart = 1'b1;
        tick();
        bus4.inStart = 1'b0;
    endtask

    task automatic wait_done(input int sel, output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (((sel == 4) ? bus4.outDone : bus1.outDone) === 1'b1) begin
                lat = i;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL wait_done instance %0d: no outDone within 20 cycles", sel);
    endtask

    initial begin
        int lat;
        int dn;
        logic [6:0] bp;
        logic exp_ovf;
        m4 = '{default: 0};
        m1 = '{default: 0};
        bus4.inStart = 0; bus4.inA = '0; bus4.inB = '0; bus4.inCarry = 0;
        bus1.inStart = 0; bus1.inA = '0; bus1.inB = '0; bus1.inCarry = 0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", 64'(bus4.outBusy), 64'd0);
        chk("reset_sum", bus4.outSum, 64'd0);

        // carry ripple across all slices
        start4(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        wait_done(4, lat);
        chk("ripple_lat", 64'(lat), 64'd5);
        chk("ripple_sum", bus4.outSum, 64'd0);
        chk("ripple_carry", 64'(bus4.outCarry), 64'd1);
        chk("ripple_ovf", 64'(bus4.outOverflow), 64'd0);
        tick();

        // signed overflow
        start4(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        wait_done(4, lat);
`ifdef ADDER_SEQ_OVERFLOW_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        chk("ovf_sum", bus4.outSum, 64'h8000_0000_0000_0000);
        chk("ovf_carry", 64'(bus4.outCarry), 64'd0);
        chk("ovf_flag", 64'(bus4.outOverflow), 64'(exp_ovf));
        tick();

        // start while busy
        bus4.inA = 64'h1234; bus4.inB = 64'h1; bus4.inCarry = 0; bus4.inStart = 1;
        dn = 0;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) begin
                bus4.inStart = (c == 2 || c == 5);
                bus4.inA = (c == 2 || c == 5) ? 64'hFFFF : 64'h1234;
            end
            @(negedge clk);
            bp[c] = bus4.outBusy;
            if (bus4.outDone === 1'b1) dn++;
            tick();
        end
        bus4.inStart = 0;
        chk("busy_pattern", 64'(bp), 64'b0111110);
        chk("busy_done_count", 64'(dn), 64'd1);
        chk("busy_sum", bus4.outSum, 64'h1235);

        // operands change after acceptance
        start4(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            bus4.inA = {$urandom, $urandom};
            bus4.inB = {$urandom, $urandom};
            bus4.inCarry = 1'($urandom);
            @(negedge clk);
            if (bus4.outDone === 1'b1) lat = i;
            tick();
        end
        chk("capture_lat", 64'(lat), 64'd5);
        chk("capture_sum", bus4.outSum, 64'h1234_5678_9ABC_DF00);
        chk("capture_carry", 64'(bus4.outCarry), 64'd0);
        bus4.inA = '0; bus4.inB = '0; bus4.inCarry = 0;

        // reset in RUN at cycle 3
        start4(64'h0001_0000_0000_FFFF, 64'd1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(bus4.outBusy), 64'd0);
        chk("abort_done", 64'(bus4.outDone), 64'd0);
        chk("abort_sum", bus4.outSum, 64'd0);
        tick();
        repeat (6) tick();
        start4(64'h0001_0000_0000_FFFF, 64'd1, 1'b0);
        wait_done(4, lat);
        chk("fresh_sum", bus4.outSum, 64'h0001_0000_0001_0000);
        tick();

        // reset wins over a simultaneous start
        rst = 1'b1;
        bus4.inA = 64'd5; bus4.inStart = 1'b1;
        tick();
        rst = 1'b0;
        bus4.inStart = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", 64'(bus4.outBusy), 64'd0);
        tick();

        // single slice
        bus1.inA = 16'hFFFF; bus1.inB = 16'hFFFF; bus1.inCarry = 1; bus1.inStart = 1;
        tick();
        bus1.inStart = 0;
        wait_done(1, lat);
        chk("n1_lat", 64'(lat), 64'd2);
        chk("n1_sum", 64'(bus1.outSum), 64'hFFFF);
        chk("n1_carry", 64'(bus1.outCarry), 64'd1);
        tick();
        dn = done1_cnt;
        for (int k = 0; k < 4; k++) begin
            bus1.inA = 16'(16'h1000 * k + 16'h0F0F);
            bus1.inB = 16'(16'h7001 + k);
            bus1.inCarry = 1'(k);
            bus1.inStart = 1;
            tick();
            bus1.inStart = 0;
            tick();
            tick();
        end
        tick();
        chk("n1_b2b_count", 64'(done1_cnt - dn), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
